// File: rtl/ram_rd_check.sv
// RAM read-back checker: sweeps addresses 0..DEPTH-1 and compares the
// returned words against the pattern (addr + SEED), reporting a pass/fail summary.
module ram_rd_check #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int SEED   = 0
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [5:0]        err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lat_q, lat_d;
    logic [5:0]        err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic              pass_q, pass_d;

    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] padr_q [RD_LAT];

    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] exp_word;
    logic              mism;

    assign cmp_vld  = vld_q[RD_LAT-1];
    assign cmp_addr = padr_q[RD_LAT-1];
    assign exp_word = DATA_W'(cmp_addr) + DATA_W'(SEED);
    assign mism     = cmp_vld && (rd_data != exp_word);

    assign rd_en          = (state_q == S_READ);
    assign rd_addr        = addr_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;

    // Next-state: sequencing plus mismatch accounting; pass uses the final count
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        pass_d  = pass_q;
        if (mism) begin
            if (err_q != 6'd63) err_d = err_q + 6'd1;
            if (err_q == 6'd0) ferr_d = cmp_addr;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                    lat_d   = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == 6'd0);
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lat_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pass_q  <= pass_d;
        end
    end

    // Delay line aligning each issued address with its returned word
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) padr_q[i] <= '0;
        end else begin
            vld_q[0]  <= rd_en;
            padr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                padr_q[i] <= padr_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: two instances (read latency 1 and 2) on behavioural
// RAMs, a pass-level reference model and directed scenarios.
module tb_ram_rd_check;

    localparam int DEPTH = 32;

    logic            sys_clk = 1'b0;
    logic            rst_n   = 1'b0;
    logic            start   = 1'b0;
    logic [1:0]      rd_en_w;
    logic [1:0][5:0] rd_addr_w;
    logic [1:0][7:0] rd_data_w;
    logic [1:0]      busy_w, done_w, pass_w;
    logic [1:0][5:0] err_w, ferr_w;

    logic [7:0] mem [2][64];
    logic [7:0] pipe1;

    int checks = 0;
    int errors = 0;

    int t [2]     = '{-1, -1};
    int LEN [2]   = '{DEPTH + 1 + 1, DEPTH + 2 + 1};
    int e_err [2] = '{0, 0};
    int e_fst [2] = '{0, 0};
    int e_pas [2] = '{0, 0};

    always #5 sys_clk = ~sys_clk;

    ram_rd_check #(.RD_LAT(1)) u0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
        .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_cnt(err_w[0]), .first_err_addr(ferr_w[0])
    );

    ram_rd_check #(.RD_LAT(2)) u1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
        .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_cnt(err_w[1]), .first_err_addr(ferr_w[1])
    );

    // Synchronous RAMs with one and two clocks of read latency
    always @(posedge sys_clk) begin
        rd_data_w[0] <= mem[0][rd_addr_w[0]];
        pipe1        <= mem[1][rd_addr_w[1]];
        rd_data_w[1] <= pipe1;
    end

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d time=%0t", nm, act, exp, $time);
        end
    endfunction

    // Expected pass result straight from RAM contents
    function automatic void eval(int u);
        int c;
        int f;
        c = 0;
        f = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (mem[u][a] != 8'(a)) begin
                c++;
                if (f < 0) f = a;
            end
        end
        e_err[u] = (c > 63) ? 63 : c;
        e_fst[u] = (f < 0) ? 0 : f;
        e_pas[u] = (c == 0) ? 1 : 0;
    endfunction

    // Model: t = clocks since accepted start, -1 when idle
    always @(posedge sys_clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                t[u] = -1;
                e_err[u] = 0;
                e_fst[u] = 0;
                e_pas[u] = 0;
            end else if (t[u] < 0) begin
                if (start) begin
                    t[u] = 1;
                    e_err[u] = 0;
                    e_fst[u] = 0;
                    e_pas[u] = 0;
                end
            end else if (t[u] == LEN[u]) begin
                t[u] = -1;
            end else begin
                t[u] = t[u] + 1;
                if (t[u] == LEN[u]) eval(u);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge sys_clk) begin
        for (int u = 0; u < 2; u++) begin
            int tt;
            int en;
            tt = t[u];
            en = (tt >= 1 && tt <= DEPTH) ? 1 : 0;
            chk($sformatf("rd_en[%0d]", u), int'(rd_en_w[u]), en);
            chk($sformatf("rd_addr[%0d]", u), int'(rd_addr_w[u]),
                (en != 0) ? tt - 1 : 0);
            chk($sformatf("busy[%0d]", u), int'(busy_w[u]), (tt >= 1) ? 1 : 0);
            chk($sformatf("done[%0d]", u), int'(done_w[u]),
                (tt == LEN[u]) ? 1 : 0);
            chk($sformatf("pass[%0d]", u), int'(pass_w[u]),
                (tt >= 1 && tt < LEN[u]) ? 0 : e_pas[u]);
            if (tt < 1 || tt == LEN[u]) begin
                chk($sformatf("err_cnt[%0d]", u), int'(err_w[u]), e_err[u]);
                chk($sformatf("first_err[%0d]", u), int'(ferr_w[u]), e_fst[u]);
            end
        end
    end

    task automatic fill_good(int u);
        for (int a = 0; a < 64; a++) mem[u][a] = 8'(a);
    endtask

    // Pulse start, wait for both done pulses; d0/d1 = clocks from start
    task automatic run_pass(input bit ign, output int d0, output int d1);
        d0 = 0;
        d1 = 0;
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge sys_clk);
            if (done_w[0] && d0 == 0) d0 = n;
            if (done_w[1] && d1 == 0) d1 = n;
            start = (ign && (n == 3 || n == 10)) ? 1'b1 : 1'b0;
            if (d0 != 0 && d1 != 0) break;
        end
        start = 1'b0;
        if (d0 == 0 || d1 == 0) begin
            errors++;
            $display("FAIL done_timeout got=%0d/%0d want=nonzero", d0, d1);
        end
        @(negedge sys_clk);
    endtask

    initial begin
        int d0;
        int d1;
        fill_good(0);
        for (int a = 0; a < 64; a++) mem[1][a] = ~8'(a);

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_err", int'(err_w[0]), 0);
        chk("rst_pass", int'(pass_w[0]), 0);
        @(posedge sys_clk);
        #1 rst_n = 1'b1;

        // Clean RAM on lat1, all-wrong RAM on lat2
        run_pass(1'b0, d0, d1);
        chk("clean_len", d0, 34);
        chk("clean_err", int'(err_w[0]), 0);
        chk("clean_pass", int'(pass_w[0]), 1);
        chk("lat2_len", d1, 35);
        chk("lat2_err", int'(err_w[1]), 32);
        chk("lat2_first", int'(ferr_w[1]), 0);
        chk("lat2_pass", int'(pass_w[1]), 0);
        fill_good(1);

        // Two corrupted words
        mem[0][5]  = 8'hFF;
        mem[0][20] = 8'hFF;
        run_pass(1'b0, d0, d1);
        chk("two_err", int'(err_w[0]), 2);
        chk("two_first", int'(ferr_w[0]), 5);
        chk("two_pass", int'(pass_w[0]), 0);

        // Only the last word wrong
        fill_good(0);
        mem[0][31] = 8'hFF;
        run_pass(1'b0, d0, d1);
        chk("last_err", int'(err_w[0]), 1);
        chk("last_first", int'(ferr_w[0]), 31);
        chk("last_pass", int'(pass_w[0]), 0);

        // Starts while busy are ignored
        fill_good(0);
        run_pass(1'b1, d0, d1);
        chk("ign_len", d0, 34);
        chk("ign_pass", int'(pass_w[0]), 1);

        // Reset mid-pass at rd_addr 12
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        repeat (12) @(posedge sys_clk);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_done", int'(done_w[0]), 0);
        chk("abort_addr", int'(rd_addr_w[0]), 0);
        chk("abort_pass", int'(pass_w[0]), 0);
        @(posedge sys_clk);
        #1 rst_n = 1'b1;
        run_pass(1'b0, d0, d1);
        chk("fresh_len", d0, 34);
        chk("fresh_pass", int'(pass_w[0]), 1);
        chk("fresh_err", int'(err_w[0]), 0);

        repeat (3) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
